// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared types and constants for the FIR front-end sequencer.
//   fir_seq_state_t   : sequencer FSM states
//   FIR_SEQ_WD_MARGIN : cycles of slack the watchdog allows beyond the tap count
//   FIR_SEQ_DATA_W    : sample width of the filter datapath
package fir_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } fir_seq_state_t;

  localparam int FIR_SEQ_WD_MARGIN = 16;
  localparam int FIR_SEQ_DATA_W    = 16;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: small synchronous FIFO for signed samples.
//   Parameters: DEPTH (power of two, >= 2), DATA_W (sample width).
//   Ports:
//     clock, reset      : clock, synchronous active-high reset (pointers only)
//     push, push_data   : write request and data; ignored while full
//     pop               : read request; ignored while empty
//     head              : oldest entry, read from registered storage
//     full, empty       : occupancy flags derived from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module sample_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic signed [DATA_W-1:0] push_data,
  input  logic                     pop,
  output logic signed [DATA_W-1:0] head,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic signed [DATA_W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage holds data only; emptiness after reset comes from the pointers.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: front-end controller for the shared 16-bit FIR datapath.
// Buffers strobed samples, issues them one at a time to the filter, captures
// each result, optionally decimates the output stream and flags a stalled
// filter.
//   Parameters: FIR_LEN (tap count, sets watchdog limit), FIFO_DEPTH,
//               DECIM (output decimation ratio, used only with FIR_SEQ_DECIM_EN)
//   Ports:
//     clock, reset            : clock, synchronous active-high reset
//     in_data, in_strobe      : incoming sample and its one-cycle valid
//     fir_data, fir_ready     : sample and one-cycle issue pulse to the filter
//     fir_result, fir_valid   : filter output and its valid
//     out_data, out_strobe    : last accepted filtered sample and update pulse
//     busy                    : sample in flight in the filter
//     overflow, timeout       : sticky error flags, cleared by err_clear
//     err_clear               : clears both sticky flags
// Build option: define FIR_SEQ_DECIM_EN to enable output decimation by DECIM.
module fir_sequencer
  import fir_seq_pkg::*;
#(
  parameter int FIR_LEN    = 449,
  parameter int FIFO_DEPTH = 4,
  parameter int DECIM      = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic signed [FIR_SEQ_DATA_W-1:0] in_data,
  input  logic                             in_strobe,
  output logic signed [FIR_SEQ_DATA_W-1:0] fir_data,
  output logic                             fir_ready,
  input  logic signed [FIR_SEQ_DATA_W-1:0] fir_result,
  input  logic                             fir_valid,
  output logic signed [FIR_SEQ_DATA_W-1:0] out_data,
  output logic                             out_strobe,
  output logic                             busy,
  output logic                             overflow,
  output logic                             timeout,
  input  logic                             err_clear
);

  localparam int WD_LIMIT = FIR_LEN + FIR_SEQ_WD_MARGIN;
  localparam int WD_W     = $clog2(FIR_LEN + FIR_SEQ_WD_MARGIN + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DECIM < 1 || DECIM > 256) begin : g_param_check
    $error("fir_sequencer: FIFO_DEPTH must be a power of two >= 2, DECIM in 1..256");
  end

  fir_seq_state_t                   state;
  logic [WD_W-1:0]                  wd_cnt;
  logic signed [FIR_SEQ_DATA_W-1:0] fifo_head;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             fifo_pop;
  logic                             ovf_evt;
  logic                             wd_expire;

  // Full is sampled from the registered pointers, so a pop in the same cycle
  // does not make room for a strobe that arrives while full.
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign ovf_evt   = in_strobe && fifo_full;
  assign wd_expire = (state == S_WAIT) && !fir_valid &&
                     (wd_cnt == WD_W'(WD_LIMIT - 1));

  sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (FIR_SEQ_DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_strobe),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FIR_SEQ_DECIM_EN
  logic [7:0] decim_cnt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      fir_data   <= '0;
      fir_ready  <= 1'b0;
      out_data   <= '0;
      out_strobe <= 1'b0;
      busy       <= 1'b0;
      wd_cnt     <= '0;
`ifdef FIR_SEQ_DECIM_EN
      decim_cnt  <= '0;
`endif
    end else begin
      fir_ready  <= 1'b0;
      out_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            fir_data <= fifo_head;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Registered pulse: the filter sees ready in the cycle after
          // fir_data settled, and writes its delay line one cycle later.
          fir_ready <= 1'b1;
          wd_cnt    <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (fir_valid) begin
`ifdef FIR_SEQ_DECIM_EN
            if (decim_cnt == 8'(DECIM - 1)) begin
              out_data   <= fir_result;
              out_strobe <= 1'b1;
              decim_cnt  <= '0;
            end else begin
              decim_cnt  <= decim_cnt + 1'b1;
            end
`else
            out_data   <= fir_result;
            out_strobe <= 1'b1;
`endif
            busy  <= 1'b0;
            state <= S_GAP;
          end else if (wd_expire) begin
            busy  <= 1'b0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          // The filter ignores ready in the cycle after valid.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (err_clear) begin
        overflow <= 1'b0;
      end
      if (wd_expire) begin
        timeout <= 1'b1;
      end else if (err_clear) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed self-checking bench for fir_sequencer with a
// behavioural filter model (fixed latency, result = sample + 1).
module tb_fir_sequencer;

  localparam int FIR_LEN    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LAT        = FIR_LEN + 2;
  localparam int WD_LIMIT   = FIR_LEN + 16;
`ifdef FIR_SEQ_DECIM_EN
  localparam int DECIM = 3;
`else
  localparam int DECIM = 1;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] in_data = '0;
  logic               in_strobe = 1'b0;
  logic signed [15:0] fir_data;
  logic               fir_ready;
  logic signed [15:0] fir_result = '0;
  logic               fir_valid = 1'b0;
  logic signed [15:0] out_data;
  logic               out_strobe;
  logic               busy;
  logic               overflow;
  logic               timeout;
  logic               err_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fir_sequencer #(
    .FIR_LEN    (FIR_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DECIM      (DECIM)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .fir_data   (fir_data),
    .fir_ready  (fir_ready),
    .fir_result (fir_result),
    .fir_valid  (fir_valid),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .busy       (busy),
    .overflow   (overflow),
    .timeout    (timeout),
    .err_clear  (err_clear)
  );

  // Behavioural filter: latches the sample on ready, answers LAT+1 cycles later.
  logic        model_answer = 1'b1;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_data = '0;

  always @(posedge clock) begin
    fir_valid <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        if (model_answer) begin
          fir_valid  <= 1'b1;
          fir_result <= m_data + 16'd1;
        end
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (fir_ready) begin
      m_busy <= 1'b1;
      m_data <= fir_data;
      m_cnt  <= LAT;
    end
  end

  // Event logs sampled on the falling edge.
  logic [15:0] iss_log [64];
  int          iss_cyc [64];
  logic [15:0] out_log [64];
  int          iss_n = 0;
  int          out_n = 0;
  int          vld_n = 0;
  int          cyc = 0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (fir_ready && iss_n < 64) begin
      iss_log[iss_n] = fir_data;
      iss_cyc[iss_n] = cyc;
      iss_n = iss_n + 1;
    end
    if (out_strobe && out_n < 64) begin
      out_log[out_n] = out_data;
      out_n = out_n + 1;
    end
    if (fir_valid) vld_n = vld_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish before 200000");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fir_data"},   32'(fir_data),   32'h0);
    check({tag, "_fir_ready"},  32'(fir_ready),  32'h0);
    check({tag, "_out_data"},   32'(out_data),   32'h0);
    check({tag, "_out_strobe"}, 32'(out_strobe), 32'h0);
    check({tag, "_busy"},       32'(busy),       32'h0);
    check({tag, "_overflow"},   32'(overflow),   32'h0);
    check({tag, "_timeout"},    32'(timeout),    32'h0);
  endtask

  initial begin
    int bi, bo, k, vb, minsp, d;

    tick(3);
    check_reset_values("reset");
    reset = 1'b0;
    tick(1);

`ifdef FIR_SEQ_DECIM_EN
    // Decimation by 3: samples 0..8 give results 1..9; only 3, 6, 9 emerge.
    bo = out_n;
    for (int i = 0; i < 9; i++) begin
      vb = vld_n;
      in_data = 16'(i);
      in_strobe = 1'b1;
      tick(1);
      in_strobe = 1'b0;
      k = 0;
      while (vld_n == vb && k < 60) begin tick(1); k++; end
      check("decim_valid_seen", 32'(vld_n - vb), 32'd1);
      tick(3);
    end
    check("decim_count", 32'(out_n - bo), 32'd3);
    check("decim_out0", 32'(out_log[bo]),     32'd3);
    check("decim_out1", 32'(out_log[bo + 1]), 32'd6);
    check("decim_out2", 32'(out_log[bo + 2]), 32'd9);
`else
    // Single sample: data loads one cycle after the strobe edge, ready one later.
    bi = iss_n; bo = out_n;
    in_data = 16'sh1234;
    in_strobe = 1'b1;
    tick(1);
    in_strobe = 1'b0;
    check("single_ready_c0", 32'(fir_ready), 32'h0);
    check("single_busy_c0",  32'(busy),      32'h0);
    tick(1);
    check("single_fir_data", 32'(fir_data),  32'h1234);
    check("single_busy_c1",  32'(busy),      32'h1);
    check("single_ready_c1", 32'(fir_ready), 32'h0);
    tick(1);
    check("single_ready_c2", 32'(fir_ready), 32'h1);
    tick(1);
    check("single_ready_c3", 32'(fir_ready), 32'h0);
    k = 0;
    while (!fir_valid && k < 50) begin tick(1); k++; end
    check("single_valid_seen", 32'(fir_valid),  32'h1);
    check("single_strobe_c0",  32'(out_strobe), 32'h0);
    tick(1);
    check("single_strobe_c1",  32'(out_strobe), 32'h1);
    check("single_out_data",   32'(out_data),   32'h1235);
    tick(1);
    check("single_strobe_c2",  32'(out_strobe), 32'h0);
    check("single_busy_done",  32'(busy),       32'h0);
    check("single_issue_cnt",  32'(iss_n - bi), 32'd1);
    tick(3);

    // Burst of 4 back-to-back strobes.
    bi = iss_n; bo = out_n;
    for (int i = 1; i <= 4; i++) begin
      in_data = 16'(16'h0101 * i);
      in_strobe = 1'b1;
      tick(1);
    end
    in_strobe = 1'b0;
    k = 0;
    while (out_n - bo < 4 && k < 200) begin tick(1); k++; end
    check("burst_out_cnt",   32'(out_n - bo), 32'd4);
    check("burst_issue_cnt", 32'(iss_n - bi), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("burst_issue_data", 32'(iss_log[bi + i]), 32'(16'h0101 * (i + 1)));
      check("burst_out_data",   32'(out_log[bo + i]), 32'(16'h0101 * (i + 1) + 1));
    end
    minsp = 1000;
    for (int i = 1; i < 4; i++) begin
      d = iss_cyc[bi + i] - iss_cyc[bi + i - 1];
      if (d < minsp) minsp = d;
    end
    check("burst_spacing_ge4", 32'(minsp >= 4), 32'd1);
    check("burst_overflow",    32'(overflow),   32'h0);
    tick(3);

    // Overflow: 6 strobes from idle, 6th dropped; clear in same cycle loses.
    bi = iss_n; bo = out_n;
    for (int i = 1; i <= 6; i++) begin
      in_data = 16'(16'h1000 + i);
      in_strobe = 1'b1;
      err_clear = (i == 6);
      tick(1);
    end
    in_strobe = 1'b0;
    err_clear = 1'b0;
    check("ovf_set_beats_clear", 32'(overflow), 32'h1);
    k = 0;
    while (out_n - bo < 5 && k < 300) begin tick(1); k++; end
    tick(40);
    check("ovf_issue_cnt", 32'(iss_n - bi), 32'd5);
    check("ovf_out_cnt",   32'(out_n - bo), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("ovf_issue_data", 32'(iss_log[bi + i]), 32'(16'h1001 + i));
    end
    check("ovf_last_out", 32'(out_log[bo + 4]), 32'h1006);
    check("ovf_sticky",   32'(overflow),        32'h1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("ovf_cleared",  32'(overflow),        32'h0);

    // Timeout: filter never answers; two samples queued.
    model_answer = 1'b0;
    bi = iss_n; bo = out_n;
    in_data = 16'sh2001; in_strobe = 1'b1; tick(1);
    in_data = 16'sh2002; tick(1);
    in_strobe = 1'b0;
    k = 0;
    while (!fir_ready && k < 10) begin tick(1); k++; end
    check("to_ready_seen", 32'(fir_ready), 32'h1);
    tick(WD_LIMIT - 1);
    check("to_not_yet", 32'(timeout), 32'h0);
    tick(1);
    check("to_set",     32'(timeout), 32'h1);
    k = 0;
    while (iss_n - bi < 2 && k < 20) begin tick(1); k++; end
    check("to_next_issued",   32'(iss_n - bi),      32'd2);
    check("to_next_data",     32'(iss_log[bi + 1]), 32'h2002);
    k = 0;
    while (busy && k < 60) begin tick(1); k++; end
    check("to_busy_released", 32'(busy),            32'h0);
    check("to_no_out_strobe", 32'(out_n - bo),      32'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("to_cleared", 32'(timeout), 32'h0);
    model_answer = 1'b1;
    tick(3);

    // Reset while waiting on the filter with two samples queued.
    bi = iss_n; bo = out_n;
    for (int i = 1; i <= 3; i++) begin
      in_data = 16'(16'h3000 + i);
      in_strobe = 1'b1;
      tick(1);
    end
    in_strobe = 1'b0;
    k = 0;
    while (!fir_ready && k < 10) begin tick(1); k++; end
    tick(2);
    check("rst_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    tick(1);
    check_reset_values("rst_mid");
    reset = 1'b0;
    vb = vld_n;
    tick(40);
    check("rst_late_valid_seen", 32'(vld_n - vb), 32'd1);
    check("rst_no_out_strobe",   32'(out_n - bo), 32'd0);
    check("rst_fifo_discarded",  32'(iss_n - bi), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Front-end controller that sequences the shared 16-bit FIR filter datapath. It accepts strobed audio/ADC samples, buffers them in a small FIFO, and issues them one at a time to the filter's `ready`/`data` inputs. It captures each filter result, optionally decimates the output stream, and watches for a stalled filter. It sits between the sample source and the filter instance, and presents the filtered stream to the display path.

## Interface
- `FIR_LEN`, 449: tap count of the controlled filter; sets the watchdog limit.
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, ≥2.
- `DECIM`, 1: output decimation ratio, 1..256; only used with `FIR_SEQ_DECIM_EN`.
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  16  signed input sample.
- `in_strobe`  in  1  one-cycle "sample valid"; the source does not hold.
- `fir_data`  out  16  sample to filter `data_i`.
- `fir_ready`  out  1  one-cycle issue pulse to filter `ready_i`.
- `fir_result`  in  16  filter `data_o`.
- `fir_valid`  in  1  filter `valid_o`.
- `out_data`  out  16  last accepted filtered sample, held.
- `out_strobe`  out  1  one-cycle pulse when `out_data` updates.
- `busy`  out  1  high while a sample is in flight in the filter.
- `overflow`  out  1  sticky: a strobed sample was dropped because the FIFO was full.
- `timeout`  out  1  sticky: the filter did not answer in time.
- `err_clear`  in  1  clears `overflow` and `timeout`.

## Operation
- **FIFO write**
  - `in_strobe` with FIFO not full: push `in_data`.
  - `in_strobe` with FIFO full: drop the sample, set `overflow`.
- **FSM states**
  - `S_IDLE`: FIFO not empty → load `fir_data` from the FIFO head, pop, go to `S_ISSUE`.
  - `S_ISSUE`: drive `fir_ready`=1 for exactly this cycle, go to `S_WAIT`.
  - `S_WAIT`: on `fir_valid`, capture `fir_result` and go to `S_GAP`. If the watchdog reaches `FIR_LEN+16` first, set `timeout` and go to `S_GAP` with no capture.
  - `S_GAP`: one-cycle holdoff (the filter ignores `ready` in the cycle after `valid`), then go to `S_IDLE`.
- `fir_data` is stable from `S_ISSUE` until the next load. The filter writes its delay line the cycle after `ready`.
- `busy` = state ∈ {`S_ISSUE`, `S_WAIT`}.
- **Watchdog counter**
  - Width `$clog2(FIR_LEN+17)`.
  - Cleared on entry to `S_WAIT`.
  - Increments each cycle spent in `S_WAIT`.
- **FIFO pointers:** `$clog2(FIFO_DEPTH)+1` bits each, wrapping naturally. Full when the MSBs differ and the low bits are equal.
- **Simultaneous push and pop:** push and pop in the same cycle are both honoured. If the FIFO is full, the push is still rejected, because full is evaluated before the pop.
- **Error flags:** if `err_clear` and a new error event occur in the same cycle, the event wins and the flag stays 1.
- **Reset mid-operation:**
  - All state returns to reset values.
  - FIFO contents are discarded.
  - A `fir_valid` arriving after reset is ignored, because the FSM is in `S_IDLE`.

## Timing
- **Reset values:**
  - `fir_data`=0, `fir_ready`=0.
  - `out_data`=0, `out_strobe`=0.
  - `busy`=0, `overflow`=0, `timeout`=0.
  - FSM in `S_IDLE`, FIFO empty, decimation counter 0.
- **Latency:**
  - FIFO is registered: a strobe at cycle 0 in an idle, empty system loads `fir_data` at cycle 1 and pulses `fir_ready` at cycle 2.
  - `out_strobe` rises the cycle after `fir_valid`.
- **Throughput:** one sample per (filter latency + 3) cycles. The filter latency is about `FIR_LEN+2`.
- All outputs are registered.

## Configuration
- **`FIR_SEQ_DECIM_EN` defined:**
  - An 8-bit counter counts captured results.
  - `out_strobe`/`out_data` update only when the counter equals `DECIM-1`; the counter then wraps to 0.
  - The filter still receives every sample.
  - A timed-out sample does not advance the counter.
- **`FIR_SEQ_DECIM_EN` undefined:**
  - Every captured result updates the output.
  - The `DECIM` parameter is ignored and no counter is synthesized.

## Structure
- **Package `fir_seq_pkg`:**
  - The state enum `fir_seq_state_t` (`S_IDLE`, `S_ISSUE`, `S_WAIT`, `S_GAP`).
  - The watchdog margin constant `FIR_SEQ_WD_MARGIN = 16`.
- **Sub-module `sample_fifo`:** parameterised depth and width, with push/pop/full/empty and registered output. It is instantiated once here and is reusable.

## Test plan
- **Single sample:** with `FIR_LEN`=8 and a behavioural filter model, strobe `in_data`=0x1234 → one `fir_ready` pulse with `fir_data`=0x1234. `out_strobe` follows `fir_valid` by 1 cycle with the model's result.
- **Burst:** 4 strobes on consecutive cycles with `FIFO_DEPTH`=4 → 4 issues, in order, each separated by ≥1 `S_GAP` cycle. `overflow` stays 0.
- **Overflow:** 6 consecutive strobes while the filter is busy → the first 5 samples are processed (1 in flight + 4 buffered) and the 6th is dropped. `overflow`=1 until `err_clear`.
- **Timeout:** the model never asserts `fir_valid` → `timeout`=1 exactly `FIR_LEN+16` cycles after `S_WAIT` entry, no `out_strobe`, and the next queued sample is still issued.
- **Decimation:** with `FIR_SEQ_DECIM_EN` and `DECIM`=3, 9 samples → exactly 3 `out_strobe` pulses, carrying results 3, 6 and 9.
- **Reset mid-flight:** reset asserted during `S_WAIT` with 2 samples queued → all outputs return to reset values next cycle, and a late `fir_valid` produces no `out_strobe`.
